axi4_lite_mem_tester: RTL and testbench
=======================================

// Module: axi4_lite_mem_tester
// PURPOSE
//  Parametrised AXI4-Lite master that sweeps a DRAM window after MIG calibration.
//  Writes num_words_p beats of a selectable pattern, reads them back, checks each beat,
//  and reports sticky pass/fail LEDs plus a saturating error count.
//  Sits between the AXI4-Lite slave port of the DDR block design and the board LEDs.
//  Successor to the fixed-pattern traffic generator; used for bring-up before core DMA.
// PARAMETERS
//  addr_width_p     28    AXI address width
//  data_width_p     64    AXI data width, power of 2, >=32; wstrb width = data_width_p/8
//  base_addr_p      0     first byte address tested
//  num_words_p      256   beats per sweep, >=1
//  stop_on_error_p  0     1: end sweep at first error; 0: finish sweep
//  err_cnt_width_p  16    width of err_count_o
// PORTS
//  clk_i        in   1              AXI clock
//  reset_n_i    in   1              async active-low reset
//  start_i      in   1              pulse: begin sweep (accepted only in IDLE/DONE)
//  mode_i       in   2              pattern select, sampled at accepted start_i
//  araddr_o     out  addr_width_p   read address
//  arprot_o     out  3              constant 3'b000
//  arvalid_o    out  1   / arready_i in 1
//  rdata_i      in   data_width_p   read data
//  rresp_i      in   2              read response
//  rvalid_i     in   1   / rready_o  out 1
//  awaddr_o     out  addr_width_p   write address
//  awprot_o     out  3              constant 3'b000
//  awvalid_o    out  1   / awready_i in 1
//  wdata_o      out  data_width_p   write data
//  wstrb_o      out  data_width_p/8 constant all ones
//  wvalid_o     out  1   / wready_i  in 1
//  bresp_i      in   2              write response
//  bvalid_i     in   1   / bready_o  out 1
//  busy_o       out  1              sweep in progress
//  done_o       out  1              sweep finished; held until next accepted start
//  wr_error_o   out  1              sticky: any bresp != OKAY
//  rd_error_o   out  1              sticky: rresp != OKAY or data mismatch
//  err_count_o  out  err_cnt_width_p total errors, saturates at all ones
// BEHAVIOUR
//  Reset (async, reset_n_i=0): state IDLE; all valid/ready outputs 0; addr/data 0;
//   busy/done/errors 0; err_count 0. Mid-sweep reset drops valids same instant.
//  States: IDLE -> WR_REQ -> WR_RESP -> (WR_REQ | RD_REQ) ; RD_REQ -> RD_DATA ->
//   (RD_REQ | DONE). DONE -> WR_REQ on start_i. Single transaction outstanding.
//  start_i in IDLE/DONE: clears errors, count, done; idx=0; latches mode; next cycle WR_REQ.
//   start_i in any other state is ignored.
//  addr(idx) = base_addr_p + idx*(data_width_p/8), truncated mod 2^addr_width_p.
//  pattern(idx,mode): 0 zero-extended addr(idx); 1 ~zero-extended addr(idx);
//   2 walking one: 1 << (idx mod data_width_p); 3 idx even ? 0xAA..A : 0x55..5.
//  WR_REQ: awvalid and wvalid rise together; each drops the cycle after its own
//   handshake; addr/data stable while valid. Both accepted (same or different
//   cycles) -> WR_RESP, bready_o=1.
//  WR_RESP: on bvalid: bresp!=0 -> wr_error set, count++. Then idx==num_words_p-1
//   -> idx=0, RD_REQ; else idx++, WR_REQ.
//  RD_REQ: arvalid until arready; then RD_DATA, rready_o=1.
//  RD_DATA: on rvalid: error if rresp!=0 or rdata!=pattern(idx) -> rd_error, count++
//   (one count per beat). Last idx -> DONE; else idx++, RD_REQ.
//  stop_on_error_p=1: first error transitions to DONE after that response handshake.
//  busy_o = state not IDLE/DONE. done_o=1 only in DONE.
//  Latency per beat: >=2 cycles write, >=2 read at zero-wait slave.
//  num_words_p=1: one write, one read, DONE.
// TESTING
//  Zero-wait slave memory, mode 0, num_words 4 -> 4 AW/W/B then 4 AR/R, awaddr 0,8,16,24,
//   done_o=1, errors 0, count 0.
//  awready delayed 3 cycles, wready immediate -> wvalid drops after 1 beat, awvalid held,
//   awaddr stable, single B accepted.
//  Slave corrupts word 2 (mode 2) -> rd_error_o=1, err_count_o=1, wr_error_o=0, done_o=1.
//  bresp=SLVERR on all writes, stop_on_error_p=1 -> wr_error_o=1, count=1, DONE after beat 0.
//  reset_n_i low during RD_DATA -> all valids/ready 0 immediately; start_i later -> fresh sweep.
//  err_cnt_width_p=2, 8 mismatches -> err_count_o saturates at 3; start_i mid-sweep ignored.

Source files
------------

// File: rtl/axi4_lite_mem_tester.sv
// ============================================================================
//  Module   : axi4_lite_mem_tester
//  Purpose  : AXI4-Lite master that sweeps a DRAM window once calibration is
//             done. Writes num_words_p beats of a selectable pattern, reads
//             them back, checks every beat and reports sticky write/read
//             error flags plus a saturating error count.
//  Ports    : clk_i / reset_n_i      clock, asynchronous active-low reset
//             start_i, mode_i        sweep trigger and pattern select
//             aw*/w*/b*              AXI4-Lite write address/data/response
//             ar*/r*                 AXI4-Lite read address/data
//             busy_o, done_o         sweep status
//             wr_error_o, rd_error_o sticky error flags
//             err_count_o            saturating total error count
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4_lite_mem_tester #(
    parameter int unsigned addr_width_p    = 28,
    parameter int unsigned data_width_p    = 64,
    parameter logic [63:0] base_addr_p     = 64'd0,
    parameter int unsigned num_words_p     = 256,
    parameter bit          stop_on_error_p = 1'b0,
    parameter int unsigned err_cnt_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    input  logic [1:0]                   mode_i,
    output logic [addr_width_p-1:0]      araddr_o,
    output logic [2:0]                   arprot_o,
    output logic                         arvalid_o,
    input  logic                         arready_i,
    input  logic [data_width_p-1:0]      rdata_i,
    input  logic [1:0]                   rresp_i,
    input  logic                         rvalid_i,
    output logic                         rready_o,
    output logic [addr_width_p-1:0]      awaddr_o,
    output logic [2:0]                   awprot_o,
    output logic                         awvalid_o,
    input  logic                         awready_i,
    output logic [data_width_p-1:0]      wdata_o,
    output logic [data_width_p/8-1:0]    wstrb_o,
    output logic                         wvalid_o,
    input  logic                         wready_i,
    input  logic [1:0]                   bresp_i,
    input  logic                         bvalid_i,
    output logic                         bready_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         wr_error_o,
    output logic                         rd_error_o,
    output logic [err_cnt_width_p-1:0]   err_count_o
);

    localparam int unsigned c_strb_w = data_width_p / 8;
    localparam int unsigned c_idx_w  = (num_words_p > 1) ? $clog2(num_words_p) : 1;

    localparam logic [c_idx_w-1:0]      c_last_idx   = c_idx_w'(num_words_p - 1);
    localparam logic [addr_width_p-1:0] c_base_addr  = addr_width_p'(base_addr_p);
    localparam logic [addr_width_p-1:0] c_beat_bytes = addr_width_p'(c_strb_w);
    localparam logic [data_width_p-1:0] c_one        = data_width_p'(1);
    localparam logic [data_width_p-1:0] c_pat_even   = {(data_width_p/4){4'hA}};
    localparam logic [data_width_p-1:0] c_pat_odd    = {(data_width_p/4){4'h5}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                      r_state;
    logic [c_idx_w-1:0]          r_idx;
    logic [1:0]                  r_mode;
    logic [addr_width_p-1:0]     r_addr;
    logic [data_width_p-1:0]     r_wdata;
    logic                        r_awvalid;
    logic                        r_wvalid;
    logic                        r_arvalid;
    logic                        r_bready;
    logic                        r_rready;
    logic                        r_aw_ok;
    logic                        r_w_ok;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_wr_err;
    logic                        r_rd_err;
    logic [err_cnt_width_p-1:0]  r_err_cnt;

    // Pattern generator: the address-based patterns use the beat's byte
    // address zero-extended (or truncated) to the data width.
    function automatic logic [data_width_p-1:0] f_pattern(
        input logic [addr_width_p-1:0] addr,
        input logic [c_idx_w-1:0]      idx,
        input logic [1:0]              mode
    );
        logic [data_width_p-1:0] w_addr_ext;
        logic [31:0]             w_shift;
        w_addr_ext = data_width_p'(addr);
        w_shift    = 32'(idx) % data_width_p;
        case (mode)
            2'd0:    f_pattern = w_addr_ext;
            2'd1:    f_pattern = ~w_addr_ext;
            2'd2:    f_pattern = c_one << w_shift;
            default: f_pattern = idx[0] ? c_pat_odd : c_pat_even;
        endcase
    endfunction

    logic                        w_last;
    logic [c_idx_w-1:0]          w_next_idx;
    logic [addr_width_p-1:0]     w_next_addr;
    logic [data_width_p-1:0]     w_next_wdata;
    logic [data_width_p-1:0]     w_exp_rdata;
    logic                        w_aw_fire;
    logic                        w_w_fire;
    logic                        w_aw_done;
    logic                        w_w_done;
    logic                        w_b_err;
    logic                        w_r_err;
    logic                        w_cnt_sat;
    logic [err_cnt_width_p-1:0]  w_cnt_inc;

    assign w_last       = (r_idx == c_last_idx);
    assign w_next_idx   = r_idx + c_idx_w'(1);
    assign w_next_addr  = r_addr + c_beat_bytes;
    assign w_next_wdata = f_pattern(w_next_addr, w_next_idx, r_mode);
    assign w_exp_rdata  = f_pattern(r_addr, r_idx, r_mode);

    // A channel counts as accepted either in an earlier cycle (r_*_ok) or in
    // this one, so AW and W may complete in any order.
    assign w_aw_fire = r_awvalid & awready_i;
    assign w_w_fire  = r_wvalid & wready_i;
    assign w_aw_done = r_aw_ok | w_aw_fire;
    assign w_w_done  = r_w_ok | w_w_fire;

    assign w_b_err   = (bresp_i != 2'b00);
    assign w_r_err   = (rresp_i != 2'b00) || (rdata_i != w_exp_rdata);
    assign w_cnt_sat = &r_err_cnt;
    assign w_cnt_inc = w_cnt_sat ? r_err_cnt : (r_err_cnt + err_cnt_width_p'(1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_mode    <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
            r_aw_ok   <= 1'b0;
            r_w_ok    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_err  <= 1'b0;
            r_rd_err  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_state   <= S_WR_REQ;
                        r_idx     <= '0;
                        r_mode    <= mode_i;
                        r_addr    <= c_base_addr;
                        r_wdata   <= f_pattern(c_base_addr, '0, mode_i);
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_ok   <= 1'b0;
                        r_w_ok    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_wr_err  <= 1'b0;
                        r_rd_err  <= 1'b0;
                        r_err_cnt <= '0;
                    end
                end

                S_WR_REQ: begin
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                        r_aw_ok   <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                        r_w_ok   <= 1'b1;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_state  <= S_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end

                S_WR_RESP: begin
                    if (bvalid_i) begin
                        r_bready <= 1'b0;
                        if (w_b_err) begin
                            r_wr_err  <= 1'b1;
                            r_err_cnt <= w_cnt_inc;
                        end
                        if (w_b_err && stop_on_error_p) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (w_last) begin
                            r_state   <= S_RD_REQ;
                            r_idx     <= '0;
                            r_addr    <= c_base_addr;
                            r_arvalid <= 1'b1;
                        end else begin
                            r_state   <= S_WR_REQ;
                            r_idx     <= w_next_idx;
                            r_addr    <= w_next_addr;
                            r_wdata   <= w_next_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_ok   <= 1'b0;
                            r_w_ok    <= 1'b0;
                        end
                    end
                end

                S_RD_REQ: begin
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (rvalid_i) begin
                        r_rready <= 1'b0;
                        if (w_r_err) begin
                            r_rd_err  <= 1'b1;
                            r_err_cnt <= w_cnt_inc;
                        end
                        if (w_last || (w_r_err && stop_on_error_p)) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_RD_REQ;
                            r_idx     <= w_next_idx;
                            r_addr    <= w_next_addr;
                            r_arvalid <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Reads and writes never overlap, so one address register serves both.
    assign araddr_o    = r_addr;
    assign awaddr_o    = r_addr;
    assign arprot_o    = 3'b000;
    assign awprot_o    = 3'b000;
    assign arvalid_o   = r_arvalid;
    assign rready_o    = r_rready;
    assign awvalid_o   = r_awvalid;
    assign wdata_o     = r_wdata;
    assign wstrb_o     = {c_strb_w{1'b1}};
    assign wvalid_o    = r_wvalid;
    assign bready_o    = r_bready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign wr_error_o  = r_wr_err;
    assign rd_error_o  = r_rd_err;
    assign err_count_o = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_mem_tester.sv
// ============================================================================
//  Module   : tb_axi4_lite_mem_tester
//  Purpose  : Self-checking bench. Instance A (8 words, 2-bit error counter)
//             talks to a behavioural memory slave with programmable
//             handshake delays and read corruption; instance B (4 words,
//             stop on first error, non-zero base) sees SLVERR on writes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi4_lite_mem_tester;

    localparam int NW_A   = 8;
    localparam int BASE_B = 'h100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // ---------------- instance A ----------------
    logic        start_a = 1'b0;
    logic [1:0]  mode_a  = 2'd0;
    logic [27:0] araddr_a, awaddr_a;
    logic [2:0]  arprot_a, awprot_a;
    logic        arvalid_a, rready_a, awvalid_a, wvalid_a, bready_a;
    logic        arready_a = 1'b0, rvalid_a = 1'b0, awready_a = 1'b0;
    logic        wready_a = 1'b0, bvalid_a = 1'b0;
    logic [63:0] rdata_a = '0, wdata_a;
    logic [1:0]  rresp_a = '0, bresp_a = '0;
    logic [7:0]  wstrb_a;
    logic        busy_a, done_a, wr_err_a, rd_err_a;
    logic [1:0]  cnt_a;

    axi4_lite_mem_tester #(
        .addr_width_p(28), .data_width_p(64), .base_addr_p(64'd0),
        .num_words_p(NW_A), .stop_on_error_p(1'b0), .err_cnt_width_p(2)
    ) u_dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start_a), .mode_i(mode_a),
        .araddr_o(araddr_a), .arprot_o(arprot_a), .arvalid_o(arvalid_a), .arready_i(arready_a),
        .rdata_i(rdata_a), .rresp_i(rresp_a), .rvalid_i(rvalid_a), .rready_o(rready_a),
        .awaddr_o(awaddr_a), .awprot_o(awprot_a), .awvalid_o(awvalid_a), .awready_i(awready_a),
        .wdata_o(wdata_a), .wstrb_o(wstrb_a), .wvalid_o(wvalid_a), .wready_i(wready_a),
        .bresp_i(bresp_a), .bvalid_i(bvalid_a), .bready_o(bready_a),
        .busy_o(busy_a), .done_o(done_a), .wr_error_o(wr_err_a), .rd_error_o(rd_err_a),
        .err_count_o(cnt_a)
    );

    // ---------------- instance B ----------------
    logic        start_b = 1'b0;
    logic [1:0]  mode_b  = 2'd0;
    logic [27:0] araddr_b, awaddr_b;
    logic [2:0]  arprot_b, awprot_b;
    logic        arvalid_b, rready_b, awvalid_b, wvalid_b, bready_b;
    logic        arready_b = 1'b0, rvalid_b = 1'b0, awready_b = 1'b0;
    logic        wready_b = 1'b0, bvalid_b = 1'b0;
    logic [63:0] rdata_b = '0, wdata_b;
    logic [1:0]  rresp_b = '0, bresp_b = '0;
    logic [7:0]  wstrb_b;
    logic        busy_b, done_b, wr_err_b, rd_err_b;
    logic [15:0] cnt_b;

    axi4_lite_mem_tester #(
        .addr_width_p(28), .data_width_p(64), .base_addr_p(64'(BASE_B)),
        .num_words_p(4), .stop_on_error_p(1'b1), .err_cnt_width_p(16)
    ) u_dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start_b), .mode_i(mode_b),
        .araddr_o(araddr_b), .arprot_o(arprot_b), .arvalid_o(arvalid_b), .arready_i(arready_b),
        .rdata_i(rdata_b), .rresp_i(rresp_b), .rvalid_i(rvalid_b), .rready_o(rready_b),
        .awaddr_o(awaddr_b), .awprot_o(awprot_b), .awvalid_o(awvalid_b), .awready_i(awready_b),
        .wdata_o(wdata_b), .wstrb_o(wstrb_b), .wvalid_o(wvalid_b), .wready_i(wready_b),
        .bresp_i(bresp_b), .bvalid_i(bvalid_b), .bready_o(bready_b),
        .busy_o(busy_b), .done_o(done_b), .wr_error_o(wr_err_b), .rd_error_o(rd_err_b),
        .err_count_o(cnt_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [27:0] model_addr(input int base, input int i);
        return 28'(base + i * 8);
    endfunction

    function automatic logic [63:0] model_pat(input int base, input int i, input int mode);
        logic [63:0] a;
        a = 64'(model_addr(base, i));
        case (mode)
            0:       return a;
            1:       return ~a;
            2:       return 64'd1 << (i % 64);
            default: return (i % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
        endcase
    endfunction

    // ---------------- slave A: behavioural memory ----------------
    logic [63:0] mem [0:255];
    int          aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
    bit          r_hold = 1'b0;
    logic [7:0]  corrupt = 8'h00;
    bit          aw_got = 0, w_got = 0, ar_got = 0, aw_track = 0, w_drop_seen = 0;
    logic [27:0] aw_cap = '0, ar_cap = '0, aw_hold = '0;
    logic [63:0] w_cap = '0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, proto_viol = 0;
    logic [27:0] aw_log [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            awready_a = 0; wready_a = 0; bvalid_a = 0; arready_a = 0; rvalid_a = 0;
        end else begin
            // address must stay put while valid; valids must drop after handshake
            if (awvalid_a) begin
                if (aw_track && awaddr_a !== aw_hold) proto_viol++;
                aw_track = 1; aw_hold = awaddr_a;
            end else begin
                aw_track = 0;
            end
            if (aw_got && awvalid_a) proto_viol++;
            if (w_got && wvalid_a) proto_viol++;
            if (w_got && !wvalid_a && awvalid_a) w_drop_seen = 1;

            awready_a = awvalid_a && !aw_got && (aw_wait >= aw_delay);
            if (awvalid_a && !aw_got) aw_wait++;
            wready_a  = wvalid_a && !w_got && (w_wait >= w_delay);
            if (wvalid_a && !w_got) w_wait++;
            bvalid_a  = aw_got && w_got;
            bresp_a   = 2'b00;
            arready_a = arvalid_a && !ar_got;
            rvalid_a  = ar_got && !r_hold;
            rdata_a   = mem[ar_cap[10:3]] ^ (corrupt[ar_cap[5:3]] ? 64'h0000_0100_0000_0000 : 64'd0);
            rresp_a   = 2'b00;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (awvalid_a && awready_a) begin
                aw_got = 1; aw_cap = awaddr_a; aw_wait = 0; n_aw++; aw_log.push_back(awaddr_a);
            end
            if (wvalid_a && wready_a) begin
                w_got = 1; w_cap = wdata_a; w_wait = 0; n_w++;
            end
            if (bvalid_a && bready_a) begin
                mem[aw_cap[10:3]] = w_cap; aw_got = 0; w_got = 0; n_b++;
            end
            if (arvalid_a && arready_a) begin
                ar_got = 1; ar_cap = araddr_a; n_ar++;
            end
            if (rvalid_a && rready_a) begin
                ar_got = 0; n_r++;
            end
        end
    end

    // ---------------- slave B: always-ready, SLVERR on writes ----------------
    bit          b_aw = 0, b_w = 0, b_ar = 0;
    int          nb_b = 0, nb_ar = 0;
    logic [27:0] b_aw_addr = '0;

    always @(negedge clk) begin
        awready_b = 1; wready_b = 1; bvalid_b = b_aw && b_w; bresp_b = 2'b10;
        arready_b = 1; rvalid_b = b_ar; rdata_b = '0; rresp_b = 2'b00;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (awvalid_b && awready_b) begin b_aw = 1; b_aw_addr = awaddr_b; end
            if (wvalid_b && wready_b) b_w = 1;
            if (bvalid_b && bready_b) begin b_aw = 0; b_w = 0; nb_b++; end
            if (arvalid_b && arready_b) begin b_ar = 1; nb_ar++; end
            if (rvalid_b && rready_b) b_ar = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0; aw_track = 0;
    endtask

    task automatic start_sweep_a(input int mode);
        aw_log.delete();
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; proto_viol = 0; w_drop_seen = 0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        @(negedge clk);
        start_a = 1'b1; mode_a = 2'(mode);
        @(negedge clk);
        start_a = 1'b0;
        check("start_clears_done", 64'(done_a), 64'd0);
        check("start_sets_busy", 64'(busy_a), 64'd1);
    endtask

    task automatic wait_done_a();
        int c = 0;
        while (!done_a && c < 2000) begin @(negedge clk); c++; end
        check("done_within_budget", 64'(done_a), 64'd1);
    endtask

    task automatic check_sweep_a(input int mode, input logic [7:0] cmask);
        int ne = $countones(cmask);
        check("sweep_done", 64'(done_a), 64'd1);
        check("sweep_busy", 64'(busy_a), 64'd0);
        check("sweep_wr_err", 64'(wr_err_a), 64'd0);
        check("sweep_rd_err", 64'(rd_err_a), 64'(ne > 0));
        check("sweep_err_cnt", 64'(cnt_a), 64'((ne > 3) ? 3 : ne));
        check("n_aw", 64'(n_aw), 64'(NW_A));
        check("n_w", 64'(n_w), 64'(NW_A));
        check("n_b", 64'(n_b), 64'(NW_A));
        check("n_ar", 64'(n_ar), 64'(NW_A));
        check("n_r", 64'(n_r), 64'(NW_A));
        check("protocol", 64'(proto_viol), 64'd0);
        for (int i = 0; i < NW_A; i++) begin
            check("awaddr_seq", 64'(aw_log[i]), 64'(model_addr(0, i)));
            check("mem_content", mem[i], model_pat(0, i, mode));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int c;
        int m;
        logic [7:0] rmask;

        repeat (3) @(negedge clk);
        check("rst_awvalid", 64'(awvalid_a), 64'd0);
        check("rst_wvalid", 64'(wvalid_a), 64'd0);
        check("rst_arvalid", 64'(arvalid_a), 64'd0);
        check("rst_bready", 64'(bready_a), 64'd0);
        check("rst_rready", 64'(rready_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_errs", 64'({wr_err_a, rd_err_a}), 64'd0);
        check("rst_cnt", 64'(cnt_a), 64'd0);
        check("rst_awaddr", 64'(awaddr_a), 64'd0);
        check("rst_wdata", wdata_a, 64'd0);
        check("wstrb_ones", 64'(wstrb_a), 64'hFF);
        check("prot_zero", 64'({awprot_a, arprot_a}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_rst", 64'({busy_a, done_a}), 64'd0);

        // zero-wait sweeps in every mode, then random-delay sweeps
        for (int md = 0; md < 4; md++) begin
            aw_delay = 0; w_delay = 0;
            start_sweep_a(md); wait_done_a(); check_sweep_a(md, 8'h00);
        end
        for (int k = 0; k < 3; k++) begin
            m = int'($urandom_range(0, 3));
            aw_delay = int'($urandom_range(0, 2)); w_delay = int'($urandom_range(0, 2));
            start_sweep_a(m); wait_done_a(); check_sweep_a(m, 8'h00);
        end

        // AW stalled three cycles while W is accepted at once
        aw_delay = 3; w_delay = 0;
        start_sweep_a(0); wait_done_a(); check_sweep_a(0, 8'h00);
        check("w_dropped_before_aw", 64'(w_drop_seen), 64'd1);
        aw_delay = 0;

        // single corrupted word, then a random one
        corrupt = 8'b0000_0100;
        start_sweep_a(2); wait_done_a(); check_sweep_a(2, corrupt);
        corrupt = 8'd1 << $urandom_range(0, 7);
        m = int'($urandom_range(0, 3));
        start_sweep_a(m); wait_done_a(); check_sweep_a(m, corrupt);
        corrupt = 8'h00;

        // reset while awvalid is held by a stalled slave
        aw_delay = 1000;
        start_sweep_a(1);
        repeat (3) @(negedge clk);
        check("aw_held_stalled", 64'(awvalid_a), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_awvalid", 64'(awvalid_a), 64'd0);
        check("async_rst_busy", 64'(busy_a), 64'd0);
        @(negedge clk); rst_n = 1'b1; clear_slave(); aw_delay = 0;

        // reset while waiting in the read data phase
        r_hold = 1'b1;
        start_sweep_a(0);
        c = 0;
        while (!rready_a && c < 500) begin @(negedge clk); c++; end
        check("reached_rd_data", 64'(rready_a), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_rready", 64'(rready_a), 64'd0);
        check("async_rst_valids", 64'({awvalid_a, wvalid_a, arvalid_a, bready_a}), 64'd0);
        check("async_rst_status", 64'({busy_a, done_a, wr_err_a, rd_err_a}), 64'd0);
        @(negedge clk); rst_n = 1'b1; clear_slave(); r_hold = 1'b0;
        @(negedge clk);
        start_sweep_a(3); wait_done_a(); check_sweep_a(3, 8'h00);

        // every word corrupted: counter saturates, mid-sweep start ignored
        corrupt = 8'hFF;
        start_sweep_a(1);
        repeat (10) @(negedge clk);
        check("busy_mid_sweep", 64'(busy_a), 64'd1);
        start_a = 1'b1; mode_a = 2'd2;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(); check_sweep_a(1, 8'hFF);
        corrupt = 8'h00;

        // a clean sweep after errors must clear the sticky state
        rmask = 8'h00;
        start_sweep_a(0);
        check("errs_cleared_on_start", 64'({wr_err_a, rd_err_a, cnt_a}), 64'd0);
        wait_done_a(); check_sweep_a(0, rmask);

        // instance B: SLVERR with stop-on-error
        check("b_idle", 64'({busy_b, done_b}), 64'd0);
        @(negedge clk);
        start_b = 1'b1; mode_b = 2'($urandom_range(0, 3));
        @(negedge clk);
        start_b = 1'b0;
        c = 0;
        while (!done_b && c < 200) begin @(negedge clk); c++; end
        check("b_done", 64'(done_b), 64'd1);
        check("b_wr_err", 64'(wr_err_b), 64'd1);
        check("b_rd_err", 64'(rd_err_b), 64'd0);
        check("b_cnt", 64'(cnt_b), 64'd1);
        check("b_one_write", 64'(nb_b), 64'd1);
        check("b_no_reads", 64'(nb_ar), 64'd0);
        check("b_base_addr", 64'(b_aw_addr), 64'(BASE_B));
        check("b_busy", 64'(busy_b), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
